// File: rtl/ga_pkg.sv
// Shared types and constants for the GA generation controller.
package ga_pkg;

  localparam int FIT_W = 5;
  localparam int CNT_W = 16;
  localparam int GEN_W = 8;
  localparam int TOT_W = 24;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    FIT    = 3'd2,
    SORT   = 3'd3,
    MATE   = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } ga_ctl_state_t;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_FIT  = 2'd1;
  localparam logic [1:0] PH_SORT = 2'd2;
  localparam logic [1:0] PH_MATE = 2'd3;

  // True for the three states that wait on an engine phase and are watchdogged.
  function automatic logic is_phase_state(input ga_ctl_state_t s);
    return (s == FIT) || (s == SORT) || (s == MATE);
  endfunction

endpackage

// File: rtl/ga_phase_timer.sv
// Per-phase cycle counter with watchdog compare.
// count is inclusive of the current cycle, so a done seen on the first
// cycle of a phase reports 1.
module ga_phase_timer
  import ga_pkg::*;
#(
  parameter int LIMIT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Cycles completed in the current phase; holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Present the count including the cycle in progress and flag the watchdog limit.
  always_comb begin
    count   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    expired = enable && (count >= LIMIT_C);
  end

endmodule

// File: rtl/ga_gen_controller.sv
// Generation sequencer for a genetic-algorithm engine: launches each
// generation, waits on the fit/sort/mate phases, times them, and stops on
// convergence, the generation limit, the watchdog or an abort.
module ga_gen_controller
  import ga_pkg::*;
#(
  parameter int GENOME_LENGTH = 28,
  parameter int MAX_GEN       = 255,
  parameter int WDOG_LIMIT    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        abort,
  input  logic        done_fit,
  input  logic        done_sort,
  input  logic        done_mate,
  input  logic [4:0]  best_fitness,
  output logic        start,
  output logic        busy,
  output logic [1:0]  phase,
  output logic [7:0]  generation,
  output logic [15:0] fit_cycles,
  output logic [15:0] sort_cycles,
  output logic [15:0] mate_cycles,
  output logic [23:0] total_cycles,
  output logic        finished,
  output logic        converged,
  output logic        timeout,
  output logic        aborted
);

  localparam logic [FIT_W-1:0] FULL_SCORE = FIT_W'(GENOME_LENGTH);
  localparam logic [GEN_W-1:0] LAST_GEN   = GEN_W'(MAX_GEN);
  localparam logic [TOT_W-1:0] TOT_MAX    = '1;

  ga_ctl_state_t    state;
  ga_ctl_state_t    next_state;
  logic [FIT_W-1:0] best_q;
  logic [CNT_W-1:0] phase_count;
  logic             phase_expired;
  logic             timer_clear;
  logic             timer_enable;
  logic             counting;

  logic gen_init;
  logic gen_inc;
  logic latch_fit;
  logic latch_sort;
  logic latch_mate;
  logic set_conv;
  logic set_tmo;
  logic set_abt;

  // The counter restarts whenever the phase state is left or entered.
  assign timer_enable = is_phase_state(state);
  assign timer_clear  = !(timer_enable && (next_state == state));
  assign counting     = (state != IDLE) && (state != DONE);

  ga_phase_timer #(
    .LIMIT(WDOG_LIMIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .count  (phase_count),
    .expired(phase_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the one-cycle strobes that update the datapath.
  always_comb begin
    next_state = state;
    gen_init   = 1'b0;
    gen_inc    = 1'b0;
    latch_fit  = 1'b0;
    latch_sort = 1'b0;
    latch_mate = 1'b0;
    set_conv   = 1'b0;
    set_tmo    = 1'b0;
    set_abt    = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          gen_init   = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: next_state = FIT;
      FIT: begin
        if (done_fit) begin
          latch_fit  = 1'b1;
          next_state = SORT;
        end else if (phase_expired) begin
          set_tmo    = 1'b1;
          next_state = DONE;
        end
      end
      SORT: begin
        if (done_sort) begin
          latch_sort = 1'b1;
          next_state = MATE;
        end else if (phase_expired) begin
          set_tmo    = 1'b1;
          next_state = DONE;
        end
      end
      MATE: begin
        if (done_mate) begin
          latch_mate = 1'b1;
          next_state = CHECK;
        end else if (phase_expired) begin
          set_tmo    = 1'b1;
          next_state = DONE;
        end
      end
      CHECK: begin
        if (best_q == FULL_SCORE) begin
          set_conv   = 1'b1;
          next_state = DONE;
        end else if (generation == LAST_GEN) begin
          next_state = DONE;
        end else begin
          gen_inc    = 1'b1;
          next_state = LAUNCH;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Abort wins over any phase completion, watchdog or check outcome.
    if (abort && counting) begin
      next_state = DONE;
      set_abt    = 1'b1;
      gen_inc    = 1'b0;
      latch_fit  = 1'b0;
      latch_sort = 1'b0;
      latch_mate = 1'b0;
      set_conv   = 1'b0;
      set_tmo    = 1'b0;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    start    = (state == LAUNCH);
    busy     = (state != IDLE);
    finished = (state == DONE);
    case (state)
      FIT:     phase = PH_FIT;
      SORT:    phase = PH_SORT;
      MATE:    phase = PH_MATE;
      default: phase = PH_NONE;
    endcase
  end

  // Generation number, sticky end-of-run flags and the saturating run total.
  always_ff @(posedge clk) begin
    if (rst) begin
      generation   <= '0;
      converged    <= 1'b0;
      timeout      <= 1'b0;
      aborted      <= 1'b0;
      total_cycles <= '0;
    end else if (gen_init) begin
      generation   <= 8'd1;
      converged    <= 1'b0;
      timeout      <= 1'b0;
      aborted      <= 1'b0;
      total_cycles <= '0;
    end else begin
      if (gen_inc) begin
        generation <= generation + 1'b1;
      end
      if (set_conv) begin
        converged <= 1'b1;
      end
      if (set_tmo) begin
        timeout <= 1'b1;
      end
      if (set_abt) begin
        aborted <= 1'b1;
      end
      if (counting && (total_cycles != TOT_MAX)) begin
        total_cycles <= total_cycles + 1'b1;
      end
    end
  end

  // Per-phase cycle counts and the best score, captured as each phase completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fit_cycles  <= '0;
      sort_cycles <= '0;
      mate_cycles <= '0;
      best_q      <= '0;
    end else begin
      if (latch_fit) begin
        fit_cycles <= phase_count;
        best_q     <= best_fitness;
      end
      if (latch_sort) begin
        sort_cycles <= phase_count;
      end
      if (latch_mate) begin
        mate_cycles <= phase_count;
      end
    end
  end

endmodule

// File: tb/tb_ga_gen_controller.sv
// Directed bench for ga_gen_controller: end-of-run results are queued as
// each run is driven and compared when the finished pulse appears.
module tb_ga_gen_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        abort;
  logic        done_fit;
  logic        done_sort;
  logic        done_mate;
  logic [4:0]  best_fitness;
  logic        start;
  logic        busy;
  logic [1:0]  phase;
  logic [7:0]  generation;
  logic [15:0] fit_cycles;
  logic [15:0] sort_cycles;
  logic [15:0] mate_cycles;
  logic [23:0] total_cycles;
  logic        finished;
  logic        converged;
  logic        timeout;
  logic        aborted;

  typedef struct {
    int gen;
    int conv;
    int tmo;
    int abt;
    int fit_c;
    int sort_c;
    int mate_c;
    int starts;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mon_starts = 0;
  int   m_fit = 0;
  int   m_sort = 0;
  int   m_mate = 0;

  ga_gen_controller #(
    .GENOME_LENGTH(28),
    .MAX_GEN      (4),
    .WDOG_LIMIT   (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .abort       (abort),
    .done_fit    (done_fit),
    .done_sort   (done_sort),
    .done_mate   (done_mate),
    .best_fitness(best_fitness),
    .start       (start),
    .busy        (busy),
    .phase       (phase),
    .generation  (generation),
    .fit_cycles  (fit_cycles),
    .sort_cycles (sort_cycles),
    .mate_cycles (mate_cycles),
    .total_cycles(total_cycles),
    .finished    (finished),
    .converged   (converged),
    .timeout     (timeout),
    .aborted     (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Count start pulses per run and score each finished pulse against the queue.
  always @(negedge clk) begin
    if (rst) begin
      mon_starts = 0;
    end else begin
      if (start) mon_starts++;
      if (finished) begin
        if (sb.size() == 0) begin
          chk("unexpected_finished", {31'd0, finished}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_generation", {24'd0, generation}, mon_e.gen);
          chk("sb_converged", {31'd0, converged}, mon_e.conv);
          chk("sb_timeout", {31'd0, timeout}, mon_e.tmo);
          chk("sb_aborted", {31'd0, aborted}, mon_e.abt);
          chk("sb_fit_cycles", {16'd0, fit_cycles}, mon_e.fit_c);
          chk("sb_sort_cycles", {16'd0, sort_cycles}, mon_e.sort_c);
          chk("sb_mate_cycles", {16'd0, mate_cycles}, mon_e.mate_c);
          chk("sb_start_pulses", mon_starts, mon_e.starts);
        end
        mon_starts = 0;
      end
    end
  end

  task automatic push_exp(input int g, input int cv, input int tm, input int ab, input int st);
    exp_t e;
    e.gen = g; e.conv = cv; e.tmo = tm; e.abt = ab;
    e.fit_c = m_fit; e.sort_c = m_sort; e.mate_c = m_mate; e.starts = st;
    sb.push_back(e);
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("launch_start", {31'd0, start}, 32'd1);
  endtask

  task automatic wait_phase(input logic [1:0] ph);
    int i = 0;
    while (phase !== ph && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (phase !== ph) chk("wait_phase_bound", {30'd0, phase}, {30'd0, ph});
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy !== 1'b0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (busy !== 1'b0) chk("wait_idle_bound", {31'd0, busy}, 32'd0);
  endtask

  // Raise the phase's done on its n-th cycle, then drop it.
  task automatic run_phase(input logic [1:0] ph, input int n, input logic [4:0] bf);
    wait_phase(ph);
    repeat (n - 1) @(negedge clk);
    best_fitness = bf;
    case (ph)
      2'd1: begin done_fit = 1'b1;  m_fit = n;  end
      2'd2: begin done_sort = 1'b1; m_sort = n; end
      default: begin done_mate = 1'b1; m_mate = n; end
    endcase
    @(negedge clk);
    done_fit = 1'b0;
    done_sort = 1'b0;
    done_mate = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; abort = 1'b0;
    done_fit = 1'b0; done_sort = 1'b0; done_mate = 1'b0; best_fitness = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {31'd0, |{start, busy, phase, generation, fit_cycles, sort_cycles,
        mate_cycles, total_cycles, finished, converged, timeout, aborted}}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("start_after_reset", {31'd0, start}, 32'd0);

    // Single-generation convergence.
    start_run();
    chk("a_generation", {24'd0, generation}, 32'd1);
    run_phase(2'd1, 28, 5'd28);
    run_phase(2'd2, 45, 5'd28);
    run_phase(2'd3, 28, 5'd28);
    push_exp(1, 1, 0, 0, 1);
    wait_idle();
    chk("a_total_cycles", {8'd0, total_cycles}, 32'd103);
    @(negedge clk);
    chk("a_idle_converged_held", {31'd0, converged}, 32'd1);
    chk("a_idle_fit_held", {16'd0, fit_cycles}, 32'd28);

    // Three generations, converging on the third; run held high while busy.
    start_run();
    run = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      wait_phase(2'd1);
      chk("b_generation", {24'd0, generation}, g);
      run_phase(2'd1, 12, (g == 3) ? 5'd28 : 5'd10);
      run_phase(2'd2, 7, 5'd0);
      if (g == 3) run = 1'b0;
      run_phase(2'd3, 9, 5'd0);
    end
    push_exp(3, 1, 0, 0, 3);
    wait_idle();

    // Stop at MAX_GEN without convergence.
    start_run();
    for (int g = 1; g <= 4; g++) begin
      run_phase(2'd1, 3, 5'd5);
      run_phase(2'd2, 4, 5'd5);
      run_phase(2'd3, 5, 5'd5);
    end
    push_exp(4, 0, 0, 0, 4);
    wait_idle();
    chk("c_converged", {31'd0, converged}, 32'd0);

    // Watchdog in SORT.
    start_run();
    run_phase(2'd1, 10, 5'd5);
    push_exp(1, 0, 1, 0, 1);
    wait_phase(2'd2);
    repeat (49) @(negedge clk);
    chk("d_sort_cycle50_phase", {30'd0, phase}, 32'd2);
    chk("d_no_timeout_yet", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    chk("d_timeout_set", {31'd0, timeout}, 32'd1);
    chk("d_finished", {31'd0, finished}, 32'd1);
    chk("d_busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("d_busy_fell", {31'd0, busy}, 32'd0);

    // Abort and done_mate in the same MATE cycle.
    start_run();
    run_phase(2'd1, 6, 5'd3);
    run_phase(2'd2, 8, 5'd3);
    wait_phase(2'd3);
    push_exp(1, 0, 0, 1, 1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    done_mate = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    done_mate = 1'b0;
    chk("e_finished", {31'd0, finished}, 32'd1);
    chk("e_aborted", {31'd0, aborted}, 32'd1);
    chk("e_mate_unchanged", {16'd0, mate_cycles}, m_mate);
    repeat (10) @(negedge clk);
    #1;
    chk("e_no_further_start", mon_starts, 32'd0);
    chk("e_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of FIT, then a fresh run.
    start_run();
    wait_phase(2'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("f_reset_outputs_zero", {31'd0, |{start, busy, phase, generation, fit_cycles, sort_cycles,
        mate_cycles, total_cycles, finished, converged, timeout, aborted}}, 32'd0);
    rst = 1'b0;
    m_fit = 0; m_sort = 0; m_mate = 0;
    @(negedge clk);
    chk("f_start_after_reset", {31'd0, start}, 32'd0);
    chk("f_not_busy", {31'd0, busy}, 32'd0);
    start_run();
    chk("f_generation_restart", {24'd0, generation}, 32'd1);
    run_phase(2'd1, 20, 5'd28);
    run_phase(2'd2, 1, 5'd0);
    run_phase(2'd3, 2, 5'd0);
    push_exp(1, 1, 0, 0, 1);
    wait_idle();
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
